sram_access_ctrl: RTL and testbench
===================================

// Module: sram_access_ctrl
// PURPOSE
//  Sequences and shares the L1 data-array sync SRAM wrapper between two requesters:
//  the cache lookup path (whole-block read) and the fill/writeback engine (block write).
//  Arbitrates, holds SRAM commands until the SRAM reports not-busy, serialises block
//  writes one 32-bit word per SRAM op, and returns registered read data with a done pulse.
// PARAMETERS
//  ASSOC        1    ways per set
//  N_FRAME_BITS 1    frame (way) index width
//  N_SET_BITS   6    set index width
//  BLOCK_SIZE   2    32-bit words per block, power of 2
//  N_BLOCK_BITS 1    $clog2(BLOCK_SIZE), word index width
// PORTS
//  CLK             in  1                clock
//  nRST            in  1                asynchronous, active-high reset
//  rd_req          in  1                lookup read request, held until rd_done
//  rd_set          in  N_SET_BITS       read set index
//  rd_frame        in  N_FRAME_BITS     read way
//  rd_done         out 1                1-cycle pulse, rd_data valid this cycle
//  rd_data         out BLOCK_SIZE*32    registered block read data
//  wr_req          in  1                block write request, held until wr_done
//  wr_set          in  N_SET_BITS       write set index
//  wr_frame        in  N_FRAME_BITS     write way
//  wr_data         in  BLOCK_SIZE*32    block to write, word 0 in bits [31:0]
//  wr_done         out 1                1-cycle pulse, all words written
//  sram_set_bits   out N_SET_BITS       to SRAM set_bits
//  sram_frame_bits out N_FRAME_BITS     to SRAM frame_bits
//  sram_cs         out 1                to SRAM chip_select
//  sram_we         out 1                to SRAM write_enable
//  sram_oe         out 1                to SRAM output_enable
//  sram_word_num   out N_BLOCK_BITS     to SRAM word_num
//  sram_wdata      out 32               to SRAM input_data
//  sram_rdata      in  BLOCK_SIZE*32    from SRAM output_data
//  sram_busy       in  1                from SRAM busy
//  ctrl_busy       out 1                1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, word count=0, last_grant=WR (first tie goes to RD); all outputs 0.
//  Reset mid-op aborts the op, no done pulse; partial block writes are not rolled back.
//  FSM IDLE -> RD | WR -> RESP -> IDLE.
//  IDLE: SRAM outputs 0. If a req is high, grant one; latch set, frame (and wr_data).
//   Both high: round-robin, grant the one not granted last; update last_grant.
//  RD: cs=1, oe=1, we=0, set/frame from latch. First cycle with sram_busy==0: capture
//   sram_rdata into rd_data, -> RESP. Until then hold command unchanged.
//  WR: cs=1, we=1, oe=0, word_num=cnt, wdata=latched word[cnt]. Each cycle with
//   sram_busy==0 completes one word: cnt==BLOCK_SIZE-1 -> cnt=0, go RESP; else cnt+1.
//   Intervening busy cycles hold command; never assert we and oe together.
//  RESP: SRAM outputs 0; pulse rd_done or wr_done (matches grant) one cycle; -> IDLE.
//  Handshake: requester drops req in cycle after done; a req still high in IDLE is a
//   new request. Req/addr/data changes while granted are ignored (latched copy used).
//  rd_data holds its value until the next read capture; not cleared by writes.
//  Latency min: read = 3 cycles req->rd_done (IDLE,RD,RESP); write = 2+BLOCK_SIZE.
//  Ungranted requester waits; no request is dropped; starvation bounded by one op.
// CONFIGURATION
//  FILL_PRIORITY_EN defined: on tie in IDLE wr_req always wins (fills never wait on
//   lookups); last_grant still updated but unused. Undefined: round-robin as above.
// TESTING
//  Reset: nRST=1 with both reqs high -> all outputs 0, ctrl_busy=0; release -> RD granted.
//  Read: rd_req set=5 frame=0, SRAM block {0xB,0xA}, busy low on 2nd RD cycle ->
//   rd_done 1 cycle later, rd_data={0xB,0xA}, sram_oe high exactly 2 cycles.
//  Write, BLOCK_SIZE=2: wr set=3 frame=1 data {0x22,0x11}, busy toggling ->
//   word_num 0 wdata 0x11 then word_num 1 wdata 0x22, one wr_done; readback matches.
//  Contention: rd_req and wr_req high together, held repeatedly -> grants alternate
//   RD,WR,RD,WR; with FILL_PRIORITY_EN -> WR first on every tie.
//  Stall: sram_busy held 1 for 10 cycles in RD -> command stable, no rd_done until busy=0.
//  Reset mid-WR after word 0 -> IDLE next cycle, no wr_done, cnt=0, next write starts word 0.

Source files
------------

// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - requester and SRAM-side signal bundle for sram_access_ctrl
// slave is the controller's view; master is the environment (requesters plus SRAM wrapper).
interface sram_access_ctrl_if #(
  parameter int N_FRAME_BITS = 1,
  parameter int N_SET_BITS   = 6,
  parameter int BLOCK_SIZE   = 2,
  parameter int N_BLOCK_BITS = 1
);
  logic                      rd_req;
  logic [N_SET_BITS-1:0]     rd_set;
  logic [N_FRAME_BITS-1:0]   rd_frame;
  logic                      rd_done;
  logic [BLOCK_SIZE*32-1:0]  rd_data;
  logic                      wr_req;
  logic [N_SET_BITS-1:0]     wr_set;
  logic [N_FRAME_BITS-1:0]   wr_frame;
  logic [BLOCK_SIZE*32-1:0]  wr_data;
  logic                      wr_done;
  logic [N_SET_BITS-1:0]     sram_set_bits;
  logic [N_FRAME_BITS-1:0]   sram_frame_bits;
  logic                      sram_cs;
  logic                      sram_we;
  logic                      sram_oe;
  logic [N_BLOCK_BITS-1:0]   sram_word_num;
  logic [31:0]               sram_wdata;
  logic [BLOCK_SIZE*32-1:0]  sram_rdata;
  logic                      sram_busy;
  logic                      ctrl_busy;

  modport slave (
    input  rd_req, rd_set, rd_frame, wr_req, wr_set, wr_frame, wr_data, sram_rdata, sram_busy,
    output rd_done, rd_data, wr_done, sram_set_bits, sram_frame_bits, sram_cs, sram_we,
           sram_oe, sram_word_num, sram_wdata, ctrl_busy
  );

  modport master (
    output rd_req, rd_set, rd_frame, wr_req, wr_set, wr_frame, wr_data, sram_rdata, sram_busy,
    input  rd_done, rd_data, wr_done, sram_set_bits, sram_frame_bits, sram_cs, sram_we,
           sram_oe, sram_word_num, sram_wdata, ctrl_busy
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - arbitrates lookup reads and block writes onto the L1 data-array SRAM
// Optional FILL_PRIORITY_EN: write requests win every tie instead of round-robin.
module sram_access_ctrl #(
  parameter int ASSOC        = 1,
  parameter int N_FRAME_BITS = 1,
  parameter int N_SET_BITS   = 6,
  parameter int BLOCK_SIZE   = 2,
  parameter int N_BLOCK_BITS = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  sram_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [N_BLOCK_BITS-1:0] LAST_WORD = N_BLOCK_BITS'(BLOCK_SIZE - 1);

  if (ASSOC < 1 || ASSOC > (1 << N_FRAME_BITS)) begin : g_bad_assoc
    $error("sram_access_ctrl: ASSOC does not fit in N_FRAME_BITS");
  end

  state_t                    state;
  logic [N_BLOCK_BITS-1:0]   cnt;
  logic [N_BLOCK_BITS-1:0]   cnt_nxt;
  logic                      last_grant_wr;
  logic [BLOCK_SIZE*32-1:0]  wdata_q;
  logic                      grant_rd;
  logic                      grant_wr;

`ifdef FILL_PRIORITY_EN
  assign grant_rd = bus.rd_req && !bus.wr_req;
`else
  assign grant_rd = bus.rd_req && (!bus.wr_req || last_grant_wr);
`endif
  assign grant_wr = bus.wr_req && !grant_rd;
  assign cnt_nxt  = cnt + 1'b1;

  assign bus.ctrl_busy = (state != IDLE);

  // SRAM command lines are registered alongside the state so they never glitch.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state               <= IDLE;
      cnt                 <= '0;
      last_grant_wr       <= 1'b1;
      wdata_q             <= '0;
      bus.rd_done         <= 1'b0;
      bus.wr_done         <= 1'b0;
      bus.rd_data         <= '0;
      bus.sram_set_bits   <= '0;
      bus.sram_frame_bits <= '0;
      bus.sram_cs         <= 1'b0;
      bus.sram_we         <= 1'b0;
      bus.sram_oe         <= 1'b0;
      bus.sram_word_num   <= '0;
      bus.sram_wdata      <= '0;
    end else begin
      bus.rd_done <= 1'b0;
      bus.wr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_rd) begin
            state               <= RD;
            last_grant_wr       <= 1'b0;
            bus.sram_set_bits   <= bus.rd_set;
            bus.sram_frame_bits <= bus.rd_frame;
            bus.sram_cs         <= 1'b1;
            bus.sram_oe         <= 1'b1;
            bus.sram_we         <= 1'b0;
          end else if (grant_wr) begin
            state               <= WR;
            last_grant_wr       <= 1'b1;
            wdata_q             <= bus.wr_data;
            bus.sram_set_bits   <= bus.wr_set;
            bus.sram_frame_bits <= bus.wr_frame;
            bus.sram_cs         <= 1'b1;
            bus.sram_we         <= 1'b1;
            bus.sram_oe         <= 1'b0;
            bus.sram_word_num   <= '0;
            bus.sram_wdata      <= bus.wr_data[31:0];
          end
        end
        RD: begin
          if (!bus.sram_busy) begin
            state               <= RESP;
            bus.rd_data         <= bus.sram_rdata;
            bus.rd_done         <= 1'b1;
            {bus.sram_cs, bus.sram_we, bus.sram_oe} <= 3'b000;
            bus.sram_set_bits   <= '0;
            bus.sram_frame_bits <= '0;
          end
        end
        WR: begin
          if (!bus.sram_busy) begin
            if (cnt == LAST_WORD) begin
              state               <= RESP;
              cnt                 <= '0;
              bus.wr_done         <= 1'b1;
              {bus.sram_cs, bus.sram_we, bus.sram_oe} <= 3'b000;
              bus.sram_set_bits   <= '0;
              bus.sram_frame_bits <= '0;
              bus.sram_word_num   <= '0;
              bus.sram_wdata      <= '0;
            end else begin
              cnt                 <= cnt_nxt;
              bus.sram_word_num   <= cnt_nxt;
              bus.sram_wdata      <= wdata_q[32*cnt_nxt +: 32];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed bench for sram_access_ctrl with a behavioural SRAM
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sram_access_ctrl;
  localparam int NF = 1;
  localparam int NS = 6;
  localparam int BS = 2;
  localparam int NB = 1;

  logic CLK = 1'b0;
  logic nRST;
  int   n_tests = 0;
  int   n_fail  = 0;

  sram_access_ctrl_if #(.N_FRAME_BITS(NF), .N_SET_BITS(NS), .BLOCK_SIZE(BS), .N_BLOCK_BITS(NB)) bus ();

  sram_access_ctrl #(.ASSOC(1), .N_FRAME_BITS(NF), .N_SET_BITS(NS), .BLOCK_SIZE(BS), .N_BLOCK_BITS(NB)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Behavioural SRAM: one packed block per {set,frame}, word writes when not busy.
  logic [1:0][31:0] mem [0:127];
  logic             bd_clr;
  logic             bd_we;
  logic [6:0]       bd_idx;
  logic [63:0]      bd_data;

  always @(posedge CLK) begin
    if (bd_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (bus.sram_cs && bus.sram_we && !bus.sram_busy) begin
      mem[{bus.sram_set_bits, bus.sram_frame_bits}][bus.sram_word_num] <= bus.sram_wdata;
    end
  end

  assign bus.sram_rdata = mem[{bus.sram_set_bits, bus.sram_frame_bits}];

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       exp_we [4];
    logic [7:0] cmd;
    int         g;

`ifdef FILL_PRIORITY_EN
    exp_we = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_we = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    nRST = 1'b1;
    bus.rd_req = 1'b1;  bus.rd_set = 6'd5; bus.rd_frame = 1'b0;
    bus.wr_req = 1'b1;  bus.wr_set = 6'd3; bus.wr_frame = 1'b1;
    bus.wr_data = {32'h22, 32'h11};
    bus.sram_busy = 1'b0;
    bd_clr = 1'b1; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    step();
    bd_clr = 1'b0; bd_we = 1'b1; bd_idx = {6'd5, 1'b0}; bd_data = {32'hB, 32'hA};
    step();
    bd_we = 1'b0;
    step();

    // Reset held with both requests high
    check("rst_ctrl_busy", bus.ctrl_busy, 0);
    check("rst_cmd", {bus.sram_cs, bus.sram_we, bus.sram_oe}, 0);
    check("rst_dones", {bus.rd_done, bus.wr_done}, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_wdata", bus.sram_wdata, 0);

    // Release: first tie goes to RD; busy on the first RD cycle
    nRST = 1'b0; bus.sram_busy = 1'b1;
    step();
    check("rd1_cmd", {bus.sram_cs, bus.sram_we, bus.sram_oe}, 3'b101);
    check("rd1_addr", {bus.sram_set_bits, bus.sram_frame_bits}, {6'd5, 1'b0});
    check("rd1_ctrl_busy", bus.ctrl_busy, 1);
    step();
    check("rd2_oe", bus.sram_oe, 1);
    check("rd2_no_done", bus.rd_done, 0);
    bus.sram_busy = 1'b0;
    step();
    check("rd_resp_done", bus.rd_done, 1);
    check("rd_resp_data", bus.rd_data, {32'hB, 32'hA});
    check("rd_resp_oe_off", {bus.sram_cs, bus.sram_oe}, 0);
    bus.rd_req = 1'b0;
    step();
    check("rd_idle_done_low", bus.rd_done, 0);
    check("rd_idle_ctrl_busy", bus.ctrl_busy, 0);
    bus.sram_busy = 1'b1;

    // Block write with busy toggling
    step();
    check("wr1_cmd", {bus.sram_cs, bus.sram_we, bus.sram_oe}, 3'b110);
    check("wr1_word", {bus.sram_word_num, bus.sram_wdata}, {1'b0, 32'h11});
    check("wr1_addr", {bus.sram_set_bits, bus.sram_frame_bits}, {6'd3, 1'b1});
    step();
    check("wr2_hold", {bus.sram_word_num, bus.sram_wdata}, {1'b0, 32'h11});
    bus.sram_busy = 1'b0;
    step();
    check("wr3_word", {bus.sram_word_num, bus.sram_wdata}, {1'b1, 32'h22});
    bus.wr_data = {32'hDEAD, 32'hBEEF};
    bus.sram_busy = 1'b1;
    step();
    check("wr4_hold", {bus.sram_word_num, bus.sram_wdata, bus.wr_done}, {1'b1, 32'h22, 1'b0});
    bus.sram_busy = 1'b0;
    step();
    check("wr_resp_done", bus.wr_done, 1);
    check("wr_resp_cmd", {bus.sram_cs, bus.sram_we, bus.sram_oe}, 0);
    check("wr_rd_data_kept", bus.rd_data, {32'hB, 32'hA});
    bus.wr_req = 1'b0;
    step();
    check("wr_idle_done_low", bus.wr_done, 0);
    check("wr_mem", mem[{6'd3, 1'b1}], {32'h22, 32'h11});

    // Readback at minimum latency
    bus.rd_req = 1'b1; bus.rd_set = 6'd3; bus.rd_frame = 1'b1;
    step();
    check("rb_rd_cycle", {bus.sram_oe, bus.rd_done}, 2'b10);
    step();
    check("rb_done", bus.rd_done, 1);
    check("rb_data", bus.rd_data, {32'h22, 32'h11});
    bus.rd_req = 1'b0;
    step();

    // Contention from reset with both requests held
    nRST = 1'b1;
    step();
    nRST = 1'b0;
    bus.rd_req = 1'b1; bus.rd_set = 6'd5; bus.rd_frame = 1'b0;
    bus.wr_req = 1'b1; bus.wr_set = 6'd9; bus.wr_frame = 1'b0;
    for (int op = 0; op < 4; op++) begin
      g = 0;
      while (!bus.sram_cs && g < 20) begin step(); g++; end
      check($sformatf("ct%0d_cs_seen", op), bus.sram_cs, 1);
      check($sformatf("ct%0d_grant_we", op), bus.sram_we, exp_we[op]);
      g = 0;
      while (!(bus.rd_done || bus.wr_done) && g < 20) begin step(); g++; end
      check($sformatf("ct%0d_done", op), {bus.wr_done, bus.rd_done}, {exp_we[op], !exp_we[op]});
      step();
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;

    // Stall: busy held in RD keeps the command stable
    nRST = 1'b1;
    step();
    nRST = 1'b0;
    bus.rd_req = 1'b1; bus.rd_set = 6'd12; bus.rd_frame = 1'b1; bus.sram_busy = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      cmd = {bus.sram_cs, bus.sram_we, bus.sram_oe, bus.rd_done, 4'h0};
      check($sformatf("stall%0d_cmd", i), cmd, 8'hA0);
      check($sformatf("stall%0d_addr", i), {bus.sram_set_bits, bus.sram_frame_bits}, {6'd12, 1'b1});
      bus.rd_set = 6'(i + 20);
      step();
    end
    bus.sram_busy = 1'b0;
    step();
    check("stall_done", bus.rd_done, 1);
    bus.rd_req = 1'b0;
    step();

    // Reset in the middle of a block write
    bus.wr_req = 1'b1; bus.wr_set = 6'd7; bus.wr_frame = 1'b0; bus.wr_data = {32'h44, 32'h33};
    step();
    check("mid_w0", {bus.sram_word_num, bus.sram_wdata}, {1'b0, 32'h33});
    step();
    check("mid_w1", {bus.sram_word_num, bus.sram_wdata}, {1'b1, 32'h44});
    nRST = 1'b1;
    #1;
    check("mid_rst_cmd", {bus.ctrl_busy, bus.sram_cs, bus.sram_we, bus.sram_word_num}, 0);
    step();
    check("mid_rst_no_done", bus.wr_done, 0);
    bus.wr_set = 6'd8; bus.wr_data = {32'h66, 32'h55};
    nRST = 1'b0;
    step();
    check("mid_restart_w0", {bus.sram_word_num, bus.sram_wdata}, {1'b0, 32'h55});
    check("mid_partial_mem", mem[{6'd7, 1'b0}], {32'h0, 32'h33});
    step();
    step();
    check("mid_restart_done", bus.wr_done, 1);
    bus.wr_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
